// File: rtl/uart_pkg.sv
// uart_pkg: state encoding and oversampling constants shared by the UART receiver and transmitter.
package uart_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} state_t;
  localparam int OVERSAMPLE = 16;
  localparam int TW = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0] MID_SAMPLE = TW'(7);
  localparam logic [TW-1:0] LAST_SAMPLE = TW'(15);
endpackage

// File: rtl/uart_sync_ff.sv
// uart_sync_ff: multi-stage synchronizer for an asynchronous line, resetting to idle-high.
module uart_sync_ff #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic [STAGES-1:0] ff;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ff <= '1;
    else ff <= {ff[STAGES-2:0], d};
  end
  assign q = ff[STAGES-1];
endmodule

// File: rtl/uart_rx_os16.sv
// uart_rx_os16: 16x-oversampled 8N1 UART receiver with framing-error detection.
// Define UART_RX_PARITY_EN to expect a parity bit between data and stop (PARITY_ODD selects odd).
module uart_rx_os16
  import uart_pkg::*;
#(
  parameter int DATA_BITS = 8,
  parameter int SYNC_STAGES = 2,
  parameter int PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tick16,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 framing_err,
  output logic                 parity_err,
  output logic                 busy
);
  if (DATA_BITS < 5 || DATA_BITS > 8 || SYNC_STAGES < 2 || PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_cfg
    $error("uart_rx_os16: illegal parameter combination");
  end
  localparam logic [3:0] LAST_BIT = 4'(DATA_BITS - 1);
  state_t state, state_n;
  logic [TW-1:0] tcnt, tcnt_n;
  logic [3:0] bcnt, bcnt_n;
  logic [DATA_BITS-1:0] sh, sh_n;
  logic rx_s, valid_n, ferr_n, good;
  uart_sync_ff #(.STAGES(SYNC_STAGES)) u_sync (.clk(clk), .rst(rst), .d(rx), .q(rx_s));
`ifdef UART_RX_PARITY_EN
  localparam logic ODD = 1'(PARITY_ODD);
  localparam state_t AFTER_DATA = PARITY;
  logic perr, perr_n, perr_out_n;
  assign good = !perr;
`else
  localparam state_t AFTER_DATA = STOP;
  assign good = 1'b1;
  assign parity_err = 1'b0;
`endif
  always_comb begin
    state_n = state;
    tcnt_n = tcnt;
    bcnt_n = bcnt;
    sh_n = sh;
    valid_n = 1'b0;
    ferr_n = 1'b0;
`ifdef UART_RX_PARITY_EN
    perr_n = perr;
    perr_out_n = 1'b0;
`endif
    if (tick16) begin
      tcnt_n = tcnt + 1'b1;
      case (state)
        IDLE: begin
          tcnt_n = '0;
          state_n = rx_s ? IDLE : START;
        end
        START: if (tcnt == MID_SAMPLE) begin
          state_n = rx_s ? IDLE : DATA;
          tcnt_n = '0;
          bcnt_n = '0;
`ifdef UART_RX_PARITY_EN
          perr_n = 1'b0;
`endif
        end
        DATA: if (tcnt == LAST_SAMPLE) begin
          sh_n = {rx_s, sh[DATA_BITS-1:1]};
          bcnt_n = (bcnt == LAST_BIT) ? 4'd0 : bcnt + 4'd1;
          state_n = (bcnt == LAST_BIT) ? AFTER_DATA : DATA;
        end
`ifdef UART_RX_PARITY_EN
        PARITY: if (tcnt == LAST_SAMPLE) begin
          perr_n = rx_s ^ (^sh) ^ ODD;
          state_n = STOP;
        end
`endif
        STOP: if (tcnt == LAST_SAMPLE) begin
          state_n = rx_s ? IDLE : BREAK;
          valid_n = rx_s & good;
          ferr_n = !rx_s;
`ifdef UART_RX_PARITY_EN
          perr_out_n = perr;
`endif
        end
        BREAK: state_n = rx_s ? IDLE : BREAK;
        default: state_n = IDLE;
      endcase
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      tcnt <= '0;
      bcnt <= '0;
      sh <= '0;
      rx_data <= '0;
      rx_valid <= 1'b0;
      framing_err <= 1'b0;
    end else begin
      state <= state_n;
      tcnt <= tcnt_n;
      bcnt <= bcnt_n;
      sh <= sh_n;
      rx_valid <= valid_n;
      framing_err <= ferr_n;
      if (valid_n) rx_data <= sh;
    end
  end
`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perr <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      perr <= perr_n;
      parity_err <= perr_out_n;
    end
  end
`endif
  assign busy = state != IDLE;
endmodule
